dual_issue_inst_queue: RTL and testbench

//  Circular instruction queue between the dual-fetch IF stage and the two DECODE units.
//  - Accepts up to two fetched {inst, pc, npc} triples per cycle.
//  - Presents the two oldest entries to decode/launch-select; retires 0, 1 or 2 per cycle on launch.
//  - Back-pressures IF with a full flag; flushes everything on a taken branch from the EX stage.

---
 rtl/dual_issue_inst_queue_pkg.sv | 24 ++
 rtl/dual_issue_inst_queue_mem.sv | 32 +++
 rtl/dual_issue_inst_queue.sv | 125 ++++++++++++
 tb/tb_dual_issue_inst_queue.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dual_issue_inst_queue_pkg.sv
// Shared widths, constants and the queue entry type for the dual-issue instruction queue.
package dual_issue_inst_queue_pkg;

  localparam int INST_BUS = 32;
  localparam int PC_BUS   = 32;

  // addi x0,x0,0 -- shown on an out slot that holds no entry
  localparam logic [INST_BUS-1:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef struct packed {
    logic [INST_BUS-1:0] inst;
    logic [PC_BUS-1:0]   pc;
    logic [PC_BUS-1:0]   npc;
  } iq_entry_t;

  // In-order retire count: launch2 only counts together with launch1.
  function automatic logic [1:0] launch_cnt(input logic l1, input logic l2);
    launch_cnt = l1 ? (l2 ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/dual_issue_inst_queue_mem.sv
// iq_mem: DEPTH x 96-bit entry array, two write ports, two async read ports.
module dual_issue_inst_queue_mem
  import dual_issue_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  iq_entry_t     wd1,
  input  logic          we2,
  input  logic [AW-1:0] wa2,
  input  iq_entry_t     wd2,
  input  logic [AW-1:0] ra1,
  output iq_entry_t     rd1,
  input  logic [AW-1:0] ra2,
  output iq_entry_t     rd2
);

  iq_entry_t mem_q [DEPTH];

  // Entry writes; addresses never collide, contents need no reset.
  always_ff @(posedge clk) begin
    if (we1) mem_q[wa1] <= wd1;
    if (we2) mem_q[wa2] <= wd2;
  end

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];

endmodule

// File: rtl/dual_issue_inst_queue.sv
// Circular instruction queue between dual fetch and the two decode units.
// Accepts up to two entries per cycle, presents the two oldest, retires 0..2.
module dual_issue_inst_queue
  import dual_issue_inst_queue_pkg::*;
#(
  parameter int                  DEPTH    = 8,
  parameter logic [INST_BUS-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_flag,
  input  logic [1:0]          issue,
  input  logic [INST_BUS-1:0] in1_inst,
  input  logic [PC_BUS-1:0]   in1_pc,
  input  logic [PC_BUS-1:0]   in1_npc,
  input  logic [INST_BUS-1:0] in2_inst,
  input  logic [PC_BUS-1:0]   in2_pc,
  input  logic [PC_BUS-1:0]   in2_npc,
  output logic [INST_BUS-1:0] out1_inst,
  output logic [PC_BUS-1:0]   out1_pc,
  output logic [PC_BUS-1:0]   out1_npc,
  output logic                out1_valid,
  output logic [INST_BUS-1:0] out2_inst,
  output logic [PC_BUS-1:0]   out2_pc,
  output logic [PC_BUS-1:0]   out2_npc,
  output logic                out2_valid,
  input  logic                launch1,
  input  logic                launch2,
  output logic                full
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FULL_AT = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic [1:0]    pop, push;
  logic          accept;
  logic          we1, we2;
  logic [AW-1:0] wa1, wa2;
  iq_entry_t     wd1, wd2, rd1, rd2;

  // Full looks only at the registered count, never at this cycle's launches.
  assign full   = (count_q >= FULL_AT);
  assign accept = ~full & ~rst & ~branch_flag;

  // Retire and write amounts; pop is clipped to what the queue holds.
  always_comb begin
    pop  = launch_cnt(launch1, launch2);
    if ((AW+1)'(pop) > count_q) pop = count_q[1:0];
    push = 2'd0;
    if (accept) push = 2'(issue[0]) + 2'(issue[1]);
  end

  // Compact valid slots in order: in1 at tail, in2 right behind whatever was written.
  assign we1 = accept & issue[0];
  assign we2 = accept & issue[1];
  assign wa1 = tail_q;
  assign wa2 = tail_q + AW'(issue[0]);
  assign wd1 = '{inst: in1_inst, pc: in1_pc, npc: in1_npc};
  assign wd2 = '{inst: in2_inst, pc: in2_pc, npc: in2_npc};

  // Pointer and occupancy next state; pointers wrap naturally mod DEPTH.
  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // State register: reset and a taken-branch flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || branch_flag) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  dual_issue_inst_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_iq_mem (
    .clk (clk),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .we2 (we2),
    .wa2 (wa2),
    .wd2 (wd2),
    .ra1 (head_q),
    .rd1 (rd1),
    .ra2 (head_q + AW'(1)),
    .rd2 (rd2)
  );

  // Output slots: entry when present, otherwise a NOP with zero pcs.
  always_comb begin
    out1_valid = (count_q >= (AW+1)'(1));
    out2_valid = (count_q >= (AW+1)'(2));
    out1_inst  = NOP_INST;
    out1_pc    = '0;
    out1_npc   = '0;
    out2_inst  = NOP_INST;
    out2_pc    = '0;
    out2_npc   = '0;
    if (out1_valid) begin
      out1_inst = rd1.inst;
      out1_pc   = rd1.pc;
      out1_npc  = rd1.npc;
    end
    if (out2_valid) begin
      out2_inst = rd2.inst;
      out2_pc   = rd2.pc;
      out2_npc  = rd2.npc;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C)
    else $error("count exceeded DEPTH");

endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Randomized scoreboard bench for dual_issue_inst_queue: a queue of expected
// entries is filled on accepted issues and drained by a negedge monitor.
module tb_dual_issue_inst_queue;
  import dual_issue_inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, branch_flag, launch1, launch2;
  logic [1:0]  issue;
  logic [31:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
  logic [31:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
  logic        out1_valid, out2_valid, full;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  logic [31:0] pc_ctr = 32'h0;
  iq_entry_t sb[$];

  always #5 clk = ~clk;

  dual_issue_inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .branch_flag(branch_flag), .issue(issue),
    .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
    .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc),
    .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_valid(out1_valid),
    .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_valid(out2_valid),
    .launch1(launch1), .launch2(launch2), .full(full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare visible slots against the oldest expected entries, then retire launched ones.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = sb.size();
      chk("out1_valid", 32'(out1_valid), 32'(n >= 1));
      chk("out2_valid", 32'(out2_valid), 32'(n >= 2));
      chk("full", 32'(full), 32'((DEPTH - n) < 2));
      chk("out1_inst", out1_inst, (n >= 1) ? sb[0].inst : NOP);
      chk("out1_pc",   out1_pc,   (n >= 1) ? sb[0].pc   : 32'h0);
      chk("out1_npc",  out1_npc,  (n >= 1) ? sb[0].npc  : 32'h0);
      chk("out2_inst", out2_inst, (n >= 2) ? sb[1].inst : NOP);
      chk("out2_pc",   out2_pc,   (n >= 2) ? sb[1].pc   : 32'h0);
      chk("out2_npc",  out2_npc,  (n >= 2) ? sb[1].npc  : 32'h0);
      if (!rst && !branch_flag && launch1 && n >= 1) begin
        void'(sb.pop_front());
        if (launch2 && n >= 2) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; accepted entries join the back of the scoreboard at the edge.
  task automatic cyc(input logic r, input logic bf, input logic [1:0] iss,
                     input logic l1, input logic l2);
    bit acc;
    iq_entry_t e1, e2;
    rst = r; branch_flag = bf; issue = iss; launch1 = l1; launch2 = l2;
    in1_inst = $urandom; in1_pc = pc_ctr;          in1_npc = $urandom;
    in2_inst = $urandom; in2_pc = pc_ctr + 32'h4;  in2_npc = $urandom;
    pc_ctr = pc_ctr + 32'h8;
    e1 = '{inst: in1_inst, pc: in1_pc, npc: in1_npc};
    e2 = '{inst: in2_inst, pc: in2_pc, npc: in2_npc};
    acc = !r && !bf && ((DEPTH - sb.size()) >= 2);
    @(posedge clk);
    if (r || bf) sb.delete();
    else if (acc) begin
      if (iss[0]) sb.push_back(e1);
      if (iss[1]) sb.push_back(e2);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; branch_flag = 1'b0; issue = 2'b00; launch1 = 1'b0; launch2 = 1'b0;
    in1_inst = '0; in1_pc = '0; in1_npc = '0; in2_inst = '0; in2_pc = '0; in2_npc = '0;
    cyc(1, 0, 2'b00, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 2'b00, 0, 0);
    // first dual issue at pc 0x0/0x4
    pc_ctr = 32'h0;
    cyc(0, 0, 2'b11, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    // fill to DEPTH, then an issue while full is dropped
    repeat (3) cyc(0, 0, 2'b11, 0, 0);
    cyc(0, 0, 2'b11, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    // down to 6, then simultaneous dual pop and dual push
    cyc(0, 0, 2'b00, 1, 1);
    cyc(0, 0, 2'b11, 1, 1);
    cyc(0, 0, 2'b00, 0, 0);
    // launch2 alone is not a launch
    cyc(0, 0, 2'b00, 0, 1);
    cyc(0, 0, 2'b00, 0, 0);
    // down to 5, then flush with issue and launch
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 1, 2'b11, 1, 0);
    cyc(0, 0, 2'b00, 0, 0);
    // walk both pointers to 7 with an empty queue
    cyc(0, 0, 2'b01, 0, 0);
    repeat (6) cyc(0, 0, 2'b01, 1, 0);
    cyc(0, 0, 2'b00, 1, 0);
    // single in1, single in2, across the wrap, then dual pop
    cyc(0, 0, 2'b01, 0, 0);
    cyc(0, 0, 2'b10, 0, 0);
    cyc(0, 0, 2'b00, 1, 1);
    cyc(0, 0, 2'b00, 0, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, bf, l1, l2;
      logic [1:0] iss;
      r   = ($urandom_range(0, 299) == 0);
      bf  = ($urandom_range(0, 39) == 0);
      iss = 2'($urandom);
      if ((DEPTH - sb.size()) < 2 && $urandom_range(0, 3) != 0) iss = 2'b00;
      l1  = ($urandom_range(0, 2) != 0);
      l2  = ($urandom_range(0, 2) != 0);
      cyc(r, bf, iss, l1, l2);
    end
    cyc(0, 0, 2'b00, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
